// File: rtl/snake_move_sched.sv
// Move tick generator + 2-deep direction key queue for the snake datapath; optional pause via SNAKE_PAUSE_EN.
// Latency: key press -> q_count/drop_pulse next cycle; queued dir appears with the tick that pops it.
// Backpressure: none; presses are dropped (drop_pulse) when illegal or when the queue is full.
module snake_move_sched #(
    parameter int TICK_BASE = 12_500_000,
    parameter int TICK_STEP = 625_000,
    parameter int TICK_MIN  = 2_500_000,
    parameter int LVL_MAX   = 15,
    parameter int CNT_W     = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_right,
    input  logic       key_left,
    input  logic       key_down,
    input  logic       key_up,
`ifdef SNAKE_PAUSE_EN
    input  logic       key_pause,
`endif
    input  logic [1:0] game_status,
    input  logic       add_cube,
    output logic       move_tick,
    output logic [1:0] dir,
    output logic [3:0] level,
    output logic [1:0] q_count,
    output logic       drop_pulse
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
`ifdef SNAKE_PAUSE_EN
    localparam logic [1:0] S_PAUSE = 2'd2;
`endif

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] next_period;
    logic [31:0]      lvl_red;
    logic [1:0]       q0, q1;
    logic [1:0]       cand, ref_dir;
    logic             playing, pause_tog, active, tick_now;
    logic             key_any, reject, push, pop;

    assign playing = (game_status == 2'b01);
`ifdef SNAKE_PAUSE_EN
    assign pause_tog = key_pause;
`else
    assign pause_tog = 1'b0;
`endif
    // The cycle that toggles pause neither counts nor accepts keys.
    assign active   = playing && (state == S_RUN) && !pause_tog;
    assign tick_now = active && (cnt == period - 1'b1);

    assign lvl_red     = {28'd0, level} * 32'(TICK_STEP);
    assign next_period = (lvl_red + 32'(TICK_MIN) >= 32'(TICK_BASE)) ?
                         CNT_W'(TICK_MIN) : CNT_W'(32'(TICK_BASE) - lvl_red);

    always_comb begin
        key_any = key_right | key_left | key_down | key_up;
        if (key_right)     cand = 2'b00;
        else if (key_left) cand = 2'b01;
        else if (key_down) cand = 2'b10;
        else               cand = 2'b11;
        // Legality is judged against the last direction the snake will have taken.
        if (q_count == 2'd0)      ref_dir = dir;
        else if (q_count == 2'd2) ref_dir = q1;
        else                      ref_dir = q0;
        reject = (cand == ref_dir) || (cand == (ref_dir ^ 2'b01)) || (q_count == 2'd2);
        push   = active && key_any && !reject;
        pop    = tick_now && (q_count != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            period     <= CNT_W'(TICK_BASE);
            q0         <= 2'b00;
            q1         <= 2'b00;
            q_count    <= 2'd0;
            dir        <= 2'b00;
            level      <= 4'd0;
            move_tick  <= 1'b0;
            drop_pulse <= 1'b0;
        end else if (!playing) begin
            state      <= S_IDLE;
            cnt        <= '0;
            period     <= CNT_W'(TICK_BASE);
            q0         <= 2'b00;
            q1         <= 2'b00;
            q_count    <= 2'd0;
            dir        <= 2'b00;
            level      <= 4'd0;
            move_tick  <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            move_tick  <= tick_now;
            drop_pulse <= active && key_any && reject;

            case (state)
                S_IDLE:  state <= S_RUN;
`ifdef SNAKE_PAUSE_EN
                S_RUN:   if (pause_tog) state <= S_PAUSE;
                S_PAUSE: if (pause_tog) state <= S_RUN;
`else
                S_RUN:   state <= S_RUN;
`endif
                default: state <= S_IDLE;
            endcase

            // Period only changes at a tick, so a level change never cuts an interval short.
            if (active) begin
                if (tick_now) begin
                    cnt    <= '0;
                    period <= next_period;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            if ((state != S_IDLE) && add_cube && (level != 4'(LVL_MAX)))
                level <= level + 4'd1;

            if (pop)
                dir <= q0;
            case ({push, pop})
                2'b10: begin
                    if (q_count == 2'd0) q0 <= cand;
                    else                 q1 <= cand;
                    q_count <= q_count + 2'd1;
                end
                2'b01: begin
                    q0      <= q1;
                    q_count <= q_count - 2'd1;
                end
                2'b11:   q0 <= cand;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_move_sched.sv
// Directed bench for snake_move_sched with a short tick period (20/4/8).
module tb_snake_move_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_right = 1'b0, key_left = 1'b0, key_down = 1'b0, key_up = 1'b0;
    logic [1:0] game_status = 2'b00;
    logic       add_cube = 1'b0;
    logic       move_tick;
    logic [1:0] dir;
    logic [3:0] level;
    logic [1:0] q_count;
    logic       drop_pulse;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    snake_move_sched #(
        .TICK_BASE(20), .TICK_STEP(4), .TICK_MIN(8), .LVL_MAX(15), .CNT_W(24)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .key_right(key_right), .key_left(key_left), .key_down(key_down), .key_up(key_up),
        .game_status(game_status), .add_cube(add_cube),
        .move_tick(move_tick), .dir(dir), .level(level), .q_count(q_count),
        .drop_pulse(drop_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One rising edge; inputs change and outputs are sampled on the falling edge.
    task automatic edge1();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic adv_to(input int t);
        while (cyc < t) edge1();
    endtask

    // Leave RUN for one edge, then re-enter; the entry edge is cycle 0.
    task automatic restart();
        game_status = 2'b00;
        edge1();
        game_status = 2'b01;
        edge1();
        cyc = 0;
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        chk("rst_move_tick", move_tick, 0);
        chk("rst_dir", dir, 0);
        chk("rst_level", level, 0);
        chk("rst_q_count", q_count, 0);
        chk("rst_drop", drop_pulse, 0);
        rst_n = 1'b1;
        edge1();

        // Basic tick: ticks at 20, 40, 60 with no keys
        game_status = 2'b01;
        edge1();
        cyc = 0;
        chk("entry_no_tick", move_tick, 0);
        for (int k = 1; k <= 60; k++) begin
            edge1();
            chk("basic_tick", move_tick, (k % 20 == 0) ? 1 : 0);
        end
        chk("basic_dir", dir, 2'b00);

        // Double-tap queueing and full-queue drop
        restart();
        adv_to(4);
        key_down = 1'b1; edge1(); key_down = 1'b0;
        chk("dt_q1", q_count, 1);
        key_left = 1'b1; edge1(); key_left = 1'b0;
        chk("dt_q2", q_count, 2);
        chk("dt_nodrop", drop_pulse, 0);
        key_up = 1'b1; edge1(); key_up = 1'b0;
        chk("full_drop", drop_pulse, 1);
        chk("full_q", q_count, 2);
        adv_to(19);
        chk("dt_pre_tick", move_tick, 0);
        chk("dt_pre_dir", dir, 2'b00);
        edge1();
        chk("dt_tick20", move_tick, 1);
        chk("dt_dir20", dir, 2'b10);
        chk("dt_q20", q_count, 1);
        adv_to(40);
        chk("dt_tick40", move_tick, 1);
        chk("dt_dir40", dir, 2'b01);
        chk("dt_q40", q_count, 0);

        // Illegal reversal, simultaneous keys, speed-up
        restart();
        adv_to(1);
        key_left = 1'b1; edge1(); key_left = 1'b0;
        chk("rev_drop", drop_pulse, 1);
        chk("rev_q", q_count, 0);
        edge1();
        chk("drop_one_cycle", drop_pulse, 0);
        key_down = 1'b1; key_up = 1'b1; edge1(); key_down = 1'b0; key_up = 1'b0;
        chk("prio_q", q_count, 1);
        chk("prio_silent", drop_pulse, 0);
        key_up = 1'b1; edge1(); key_up = 1'b0;
        chk("tail_rev_drop", drop_pulse, 1);
        chk("tail_rev_q", q_count, 1);
        for (int i = 0; i < 5; i++) begin
            add_cube = 1'b1; edge1(); add_cube = 1'b0;
        end
        chk("lvl5", level, 5);
        adv_to(20);
        chk("sp_tick20", move_tick, 1);
        chk("sp_dir20", dir, 2'b10);
        adv_to(27);
        chk("sp_no27", move_tick, 0);
        edge1();
        chk("sp_tick28", move_tick, 1);
        adv_to(35);
        key_left = 1'b1; edge1(); key_left = 1'b0;
        chk("pp_tick36", move_tick, 1);
        chk("pp_dir36", dir, 2'b10);
        chk("pp_q36", q_count, 1);
        adv_to(44);
        chk("pp_tick44", move_tick, 1);
        chk("pp_dir44", dir, 2'b01);
        chk("pp_q44", q_count, 0);
        for (int i = 0; i < 15; i++) begin
            add_cube = 1'b1; edge1(); add_cube = 1'b0;
        end
        chk("lvl_sat", level, 15);

        // Abort mid-interval
        restart();
        for (int i = 0; i < 3; i++) begin
            add_cube = 1'b1; edge1(); add_cube = 1'b0;
        end
        key_down = 1'b1; edge1(); key_down = 1'b0;
        key_left = 1'b1; edge1(); key_left = 1'b0;
        chk("ab_pre_q", q_count, 2);
        chk("ab_pre_lvl", level, 3);
        adv_to(9);
        game_status = 2'b00;
        edge1();
        chk("ab_q", q_count, 0);
        chk("ab_dir", dir, 0);
        chk("ab_lvl", level, 0);
        for (int k = 0; k < 30; k++) begin
            edge1();
            chk("ab_idle_tick", move_tick, 0);
        end
        game_status = 2'b01;
        edge1();
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            edge1();
            chk("ab_rerun_tick", move_tick, (k == 20) ? 1 : 0);
        end

        // Asynchronous reset just before a tick
        restart();
        adv_to(1);
        key_down = 1'b1; edge1(); key_down = 1'b0;
        add_cube = 1'b1; edge1(); add_cube = 1'b0;
        chk("ar_pre_q", q_count, 1);
        chk("ar_pre_lvl", level, 1);
        adv_to(19);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_q", q_count, 0);
        chk("ar_lvl", level, 0);
        chk("ar_dir", dir, 0);
        chk("ar_drop", drop_pulse, 0);
        chk("ar_tick", move_tick, 0);
        @(posedge clk);
        @(negedge clk);
        chk("ar_no_glitch", move_tick, 0);
        rst_n = 1'b1;
        edge1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
